// File: rtl/kernel_driver_pkg.sv
// Shared types for the kernel request driver: FSM state encoding and the
// per-vector record stored in the operand table.
package kernel_driver_pkg;

  localparam int DRV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FIN
  } drv_state_t;

  typedef struct packed {
    logic [DRV_WIDTH-1:0] x;
    logic [DRV_WIDTH-1:0] y;
    logic [DRV_WIDTH-1:0] exp;
  } drv_vec_t;

endpackage

// File: rtl/kernel_vec_mem.sv
// Operand/expected-result table. Flops rather than RAM so the read port is
// combinational and the selected operands reach the kernel in the same cycle.
module kernel_vec_mem
  import kernel_driver_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  drv_vec_t      wdata_i,
  input  logic [AW-1:0] raddr_i,
  output drv_vec_t      rdata_o
);

  drv_vec_t mem_q [DEPTH];

  // Single write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kernel_driver.sv
// Request-side driver for single-result compute kernels. Walks the vector
// table, issues one request at a time, checks each result against the stored
// expectation and reports pass/fail totals, first failing index and timeout.
module kernel_driver
  import kernel_driver_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vec_we,
  input  logic [$clog2(DEPTH)-1:0] vec_addr,
  input  logic [WIDTH-1:0]         vec_x,
  input  logic [WIDTH-1:0]         vec_y,
  input  logic [WIDTH-1:0]         vec_exp,
  input  logic [$clog2(DEPTH):0]   num_vec,
  input  logic                     start,
  input  logic                     input_ready,
  output logic                     input_valid,
  output logic [WIDTH-1:0]         x,
  output logic [WIDTH-1:0]         y,
  input  logic                     output_valid,
  input  logic [WIDTH-1:0]         res,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   pass_cnt,
  output logic [$clog2(DEPTH):0]   fail_cnt,
  output logic [$clog2(DEPTH)-1:0] first_fail,
  output logic                     timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  drv_state_t       state_q, state_d;
  logic [AW-1:0]    idx_q;
  logic [CW-1:0]    num_q;
  logic [CW-1:0]    num_start;
  logic [TW-1:0]    wcnt_q;
  logic [WIDTH-1:0] exp_q;
  logic [CW-1:0]    pass_q, fail_q;
  logic [AW-1:0]    ff_q;
  logic             to_q;
  drv_vec_t         wr_vec, rd_vec;
  logic             xfer, resp, expired, last_vec, miss;

  kernel_vec_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (vec_we && (state_q == IDLE)),
    .waddr_i (vec_addr),
    .wdata_i (wr_vec),
    .raddr_i (idx_q),
    .rdata_o (rd_vec)
  );

  assign wr_vec = '{x: DRV_WIDTH'(vec_x), y: DRV_WIDTH'(vec_y), exp: DRV_WIDTH'(vec_exp)};

  // A requested count of 0 runs one vector; anything above DEPTH runs the whole table.
  assign num_start = (num_vec == '0)     ? CW'(1)  :
                     (num_vec > DEPTH_C) ? DEPTH_C : num_vec;

  assign xfer     = (state_q == ISSUE) && input_ready;
  assign resp     = (state_q == WAIT) && output_valid;
  assign expired  = (state_q == WAIT) && !output_valid && (wcnt_q == TO_LAST);
  assign last_vec = (({1'b0, idx_q} + CW'(1)) == num_q);
  assign miss     = (resp && (res != exp_q)) || expired;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: one request outstanding at a time; a timeout abandons the run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = ISSUE;
      ISSUE: if (input_ready) state_d = WAIT;
      WAIT: begin
        if (output_valid)  state_d = last_vec ? FIN : ISSUE;
        else if (expired)  state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; operands are zero outside ISSUE.
  always_comb begin
    input_valid = 1'b0;
    x           = '0;
    y           = '0;
    busy        = 1'b1;
    done        = 1'b0;
    case (state_q)
      IDLE: busy = 1'b0;
      ISSUE: begin
        input_valid = 1'b1;
        x           = rd_vec.x[WIDTH-1:0];
        y           = rd_vec.y[WIDTH-1:0];
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Run bookkeeping: index, wait counter and the result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      num_q  <= '0;
      wcnt_q <= '0;
      pass_q <= '0;
      fail_q <= '0;
      ff_q   <= '0;
      to_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q  <= '0;
            num_q  <= num_start;
            pass_q <= '0;
            fail_q <= '0;
            ff_q   <= '0;
            to_q   <= 1'b0;
          end
        end
        ISSUE: if (input_ready) wcnt_q <= '0;
        WAIT: begin
          wcnt_q <= wcnt_q + TW'(1);
          if (resp && !miss) pass_q <= pass_q + CW'(1);
          if (miss) begin
            fail_q <= fail_q + CW'(1);
            if (fail_q == '0) ff_q <= idx_q;
          end
          if (expired) to_q <= 1'b1;
          if (resp && !last_vec) idx_q <= idx_q + AW'(1);
        end
        default: ;
      endcase
    end
  end

  // Expected value captured when the request is accepted by the kernel.
  always_ff @(posedge clk) begin
    if (xfer) exp_q <= rd_vec.exp[WIDTH-1:0];
  end

  assign pass_cnt   = pass_q;
  assign fail_cnt   = fail_q;
  assign first_fail = ff_q;
  assign timeout    = to_q;

endmodule
